debug_host: RTL and testbench

- Hardware host for the MIPS debug unit. It drives the UART link from the far side.
- Download phase: sends 'i', then streams a program from a local ROM as 4 bytes per word, MSB first, up to and including the HALT word.
- Run phase: sends 'c' (continuous) or 's' (step).
- Dump phase: receives the register/memory dump and reassembles it into 32-bit words tagged by index and kind.
- Used for board self-test and as the loopback partner in system benches.

---
 rtl/debug_host_pkg.sv | 28 ++
 rtl/debug_host_word_byte_serializer.sv | 66 ++++++
 rtl/debug_host.sv | 209 ++++++++++++++++++++
 tb/tb_debug_host.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/debug_host_pkg.sv
// debug_host_pkg: shared constants, FSM states and dump helpers for the debug host
//   HALT_INSTRUCTION  program terminator word (MIPS debug unit HALT)
//   CMD_*             ASCII commands 'i' (init/download), 's' (step), 'c' (continuous)
//   KIND_*            dump word kind codes
//   dump_words        number of words in a dump (PC + regs + ALU + mem)
//   kind_of           dump kind for a given dump index
package debug_host_pkg;
    localparam logic [31:0] HALT_INSTRUCTION = 32'hFC00_0000;
    localparam logic [7:0] CMD_INIT = 8'h69;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_CONT = 8'h63;
    localparam logic [1:0] KIND_PC  = 2'd0;
    localparam logic [1:0] KIND_REG = 2'd1;
    localparam logic [1:0] KIND_ALU = 2'd2;
    localparam logic [1:0] KIND_MEM = 2'd3;
    typedef enum logic [3:0] {
        IDLE, SEND_CMD_I, ROM_FETCH, SEND_BYTE, WAIT_TX,
        GAP, SEND_RUN, WAIT_RUN_TX, RECEIVE, DONE
    } state_t;
    function automatic int dump_words(input int nregs, input int nmem);
        return 1 + nregs + 1 + nmem;
    endfunction
    function automatic logic [1:0] kind_of(input logic [5:0] idx, input int nregs);
        return idx == 6'd0 ? KIND_PC :
               int'(idx) <= nregs ? KIND_REG :
               int'(idx) == nregs + 1 ? KIND_ALU : KIND_MEM;
    endfunction
endpackage

// File: rtl/debug_host_word_byte_serializer.sv
// word_byte_serializer: sends a word MSB-first as 4 bytes (or only its top byte) over a ready/done handshake
//   i_load     1-cycle pulse: capture i_data and start sending
//   i_one      with i_load: send only the top byte
//   i_data     word to send
//   i_tx_done  1-cycle pulse when the current byte has been sent
//   o_tx_data  byte being offered (top byte of the shift register)
//   o_tx_ready transmit request, held until i_tx_done
//   o_done     1-cycle pulse on i_tx_done of the last byte
module word_byte_serializer #(
    parameter int NB        = 32,
    parameter int DATA_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_load,
    input  logic                 i_one,
    input  logic [NB-1:0]        i_data,
    input  logic                 i_tx_done,
    output logic [DATA_BITS-1:0] o_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_done
);
    logic [NB-1:0] shift_q, shift_d;
    logic [1:0]    cnt_q, cnt_d, last_q, last_d;
    logic          active_q, active_d, ready_q, ready_d;
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        active_d = active_q;
        ready_d  = ready_q;
        o_done   = ready_q && i_tx_done && cnt_q == last_q;
        if (i_load) begin
            shift_d  = i_data;
            cnt_d    = 2'd0;
            last_d   = i_one ? 2'd0 : 2'd3;
            active_d = 1'b1;
            ready_d  = 1'b1;
        end else if (ready_q && i_tx_done) begin
            ready_d  = 1'b0;
            shift_d  = shift_q << DATA_BITS;
            cnt_d    = cnt_q + 2'd1;
            active_d = cnt_q != last_q;
        end else if (active_q && !ready_q) begin
            // re-raise only after a full cycle low following the previous done
            ready_d = 1'b1;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            active_q <= active_d;
            ready_q  <= ready_d;
        end
    end
    assign o_tx_data  = shift_q[NB-1 -: DATA_BITS];
    assign o_tx_ready = ready_q;
endmodule

// File: rtl/debug_host.sv
// debug_host: UART-side host for the MIPS debug unit: downloads a ROM program, issues run, collects the dump
//   i_start/i_mode           start pulse (IDLE only) and run mode (1 'c', 0 's')
//   o_prog_address/i_prog_data  program ROM byte address / word (valid one cycle later)
//   o_uart_tx_*/i_uart_tx_done  byte transmit handshake
//   i_uart_rx_ready/data     received dump bytes
//   o_word_*                 reassembled dump words with index and kind
//   o_busy/o_done/o_error/o_state_debug  status
module debug_host
    import debug_host_pkg::*;
#(
    parameter int NB               = 32,
    parameter int DATA_BITS        = 8,
    parameter int NUMBER_REGISTERS = 32,
    parameter int NUMBER_MEM_WORDS = 16,
    parameter int MAX_PROG_WORDS   = 64,
    parameter int GAP_CYCLES       = 16,
    parameter int TIMEOUT_CYCLES   = 1000000,
    parameter int NB_STATE         = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_mode,
    output logic [NB-1:0]        o_prog_address,
    input  logic [NB-1:0]        i_prog_data,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    output logic                 o_uart_tx_ready,
    input  logic                 i_uart_tx_done,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    output logic                 o_word_valid,
    output logic [NB-1:0]        o_word_data,
    output logic [5:0]           o_word_index,
    output logic [1:0]           o_word_kind,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [NB_STATE-1:0]  o_state_debug
);
    localparam int DUMP_WORDS = dump_words(NUMBER_REGISTERS, NUMBER_MEM_WORDS);
    localparam int WC_W = $clog2(MAX_PROG_WORDS + 1);
    localparam int GC_W = $clog2(GAP_CYCLES + 1);
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    state_t            state_q, state_d, next_q, next_d;
    logic [NB-1:0]     addr_q, addr_d, word_q, word_d, rxw_q, rxw_d, wdata_q, wdata_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [GC_W-1:0]   gap_q, gap_d;
    logic [TC_W-1:0]   tmo_q, tmo_d;
    logic [5:0]        idx_q, idx_d, windex_q, windex_d;
    logic [1:0]        bcnt_q, bcnt_d, wkind_q, wkind_d;
    logic              fetch_q, fetch_d, mode_q, mode_d, err_q, err_d, valid_q, valid_d;
    logic              ser_load, ser_one, ser_done;
    logic [NB-1:0]     ser_data;
    word_byte_serializer #(.NB(NB), .DATA_BITS(DATA_BITS)) u_ser (
        .i_clk(i_clk), .i_reset(i_reset), .i_load(ser_load), .i_one(ser_one), .i_data(ser_data),
        .i_tx_done(i_uart_tx_done), .o_tx_data(o_uart_tx_data), .o_tx_ready(o_uart_tx_ready), .o_done(ser_done)
    );
    always_comb begin
        state_d  = state_q;
        next_d   = next_q;
        addr_d   = addr_q;
        word_d   = word_q;
        rxw_d    = rxw_q;
        wdata_d  = wdata_q;
        wcnt_d   = wcnt_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        windex_d = windex_q;
        bcnt_d   = bcnt_q;
        wkind_d  = wkind_q;
        fetch_d  = fetch_q;
        mode_d   = mode_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        ser_load = 1'b0;
        ser_one  = 1'b0;
        ser_data = '0;
        case (state_q)
            IDLE: if (i_start) begin
                addr_d  = '0;
                err_d   = 1'b0;
                mode_d  = i_mode;
                wcnt_d  = '0;
                fetch_d = 1'b0;
                state_d = SEND_CMD_I;
            end
            SEND_CMD_I: begin
                ser_load = 1'b1;
                ser_one  = 1'b1;
                ser_data = {CMD_INIT, {(NB-DATA_BITS){1'b0}}};
                next_d   = ROM_FETCH;
                state_d  = WAIT_TX;
            end
            ROM_FETCH: begin
                // first cycle lets the ROM respond to the new address
                fetch_d = !fetch_q;
                if (fetch_q) begin
                    word_d  = i_prog_data;
                    state_d = SEND_BYTE;
                end
            end
            SEND_BYTE: begin
                ser_load = 1'b1;
                ser_data = word_q;
                next_d   = SEND_BYTE;
                state_d  = WAIT_TX;
            end
            WAIT_TX: if (ser_done) begin
                if (next_q == ROM_FETCH) state_d = ROM_FETCH;
                else if (word_q == NB'(HALT_INSTRUCTION)) begin
                    gap_d   = '0;
                    state_d = GAP;
                end else if (32'(wcnt_q) + 1 == MAX_PROG_WORDS) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = addr_q + NB'(4);
                    wcnt_d  = wcnt_q + 1'b1;
                    state_d = ROM_FETCH;
                end
            end
            GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = 32'(gap_q) == GAP_CYCLES - 1 ? SEND_RUN : GAP;
            end
            SEND_RUN: begin
                ser_load = 1'b1;
                ser_one  = 1'b1;
                ser_data = {mode_q ? CMD_CONT : CMD_STEP, {(NB-DATA_BITS){1'b0}}};
                state_d  = WAIT_RUN_TX;
            end
            WAIT_RUN_TX: if (ser_done) begin
                idx_d   = '0;
                bcnt_d  = '0;
                tmo_d   = '0;
                state_d = RECEIVE;
            end
            RECEIVE: begin
                if (i_uart_rx_ready) begin
                    rxw_d  = {rxw_q[NB-DATA_BITS-1:0], i_uart_rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                    tmo_d  = '0;
                    if (bcnt_q == 2'd3) begin
                        valid_d  = 1'b1;
                        wdata_d  = rxw_d;
                        windex_d = idx_q;
                        wkind_d  = kind_of(idx_q, NUMBER_REGISTERS);
                        idx_d    = idx_q + 6'd1;
                        if (idx_q == 6'(DUMP_WORDS - 1)) state_d = DONE;
                    end
                end else if (32'(tmo_q) == TIMEOUT_CYCLES - 1) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else tmo_d = tmo_q + 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            next_q   <= IDLE;
            addr_q   <= '0;
            word_q   <= '0;
            rxw_q    <= '0;
            wdata_q  <= '0;
            wcnt_q   <= '0;
            gap_q    <= '0;
            tmo_q    <= '0;
            idx_q    <= '0;
            windex_q <= '0;
            bcnt_q   <= '0;
            wkind_q  <= '0;
            fetch_q  <= 1'b0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            next_q   <= next_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            rxw_q    <= rxw_d;
            wdata_q  <= wdata_d;
            wcnt_q   <= wcnt_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
            idx_q    <= idx_d;
            windex_q <= windex_d;
            bcnt_q   <= bcnt_d;
            wkind_q  <= wkind_d;
            fetch_q  <= fetch_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end
    assign o_prog_address = addr_q;
    assign o_word_valid   = valid_q;
    assign o_word_data    = wdata_q;
    assign o_word_index   = windex_q;
    assign o_word_kind    = wkind_q;
    assign o_busy         = state_q != IDLE;
    assign o_done         = state_q == DONE;
    assign o_error        = err_q;
    assign o_state_debug  = NB_STATE'(state_q);
endmodule

// File: tb/tb_debug_host.sv
// tb_debug_host: directed scoreboard bench for debug_host
module tb_debug_host;
  localparam int GAP = 16;
  localparam int TMO = 300;
  logic        clk = 0, rst = 1, start = 0, mode = 0;
  logic [31:0] prog_address, prog_data;
  logic [7:0]  tx_data, rx_data = 0;
  logic        tx_ready, tx_done = 0, rx_ready = 0;
  logic        word_valid, busy, done, error;
  logic [31:0] word_data;
  logic [5:0]  word_index;
  logic [1:0]  word_kind;
  logic [3:0]  state_dbg;
  logic [31:0] rom [0:15];
  logic [7:0]  tx_log[$], exp_bytes[$];
  int          tx_cyc[$];
  logic [39:0] words[$], exp_words[$];
  int          total = 0, bad = 0, done_cnt = 0, cyc = 0;
  debug_host #(.MAX_PROG_WORDS(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode),
    .o_prog_address(prog_address), .i_prog_data(prog_data),
    .o_uart_tx_data(tx_data), .o_uart_tx_ready(tx_ready), .i_uart_tx_done(tx_done),
    .i_uart_rx_ready(rx_ready), .i_uart_rx_data(rx_data),
    .o_word_valid(word_valid), .o_word_data(word_data), .o_word_index(word_index), .o_word_kind(word_kind),
    .o_busy(busy), .o_done(done), .o_error(error), .o_state_debug(state_dbg)
  );
  always #5 clk = ~clk;
  always @(posedge clk) prog_data <= rom[prog_address[5:2]];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (word_valid) words.push_back({word_index, word_kind, word_data});
    if (done) done_cnt++;
  end
  initial forever begin
    @(negedge clk);
    if (tx_ready === 1'b1) begin
      tx_log.push_back(tx_data);
      tx_cyc.push_back(cyc);
      repeat (2) @(negedge clk);
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start(input logic m);
    @(negedge clk);
    start = 1;
    mode = m;
    @(negedge clk);
    start = 0;
  endtask
  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1;
    rx_data = b;
    @(negedge clk);
    rx_ready = 0;
  endtask
  task automatic push_word_bytes(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(w[i*8 +: 8]);
  endtask
  task automatic push_dump_word(input int n);
    logic [1:0] k;
    k = n == 0 ? 2'd0 : n <= 32 ? 2'd1 : n == 33 ? 2'd2 : 2'd3;
    exp_words.push_back({6'(n), k, {4{8'(n)}}});
  endtask
  task automatic wait_tx(input int n);
    for (int k = 0; k < 3000 && tx_log.size() < n; k++) @(negedge clk);
    chk("tx_byte_count", tx_log.size(), n);
  endtask
  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) @(negedge clk);
    chk("return_idle", state_dbg, 4'd0);
  endtask
  task automatic check_bytes(input string tag);
    while (exp_bytes.size() > 0 && tx_log.size() > 0) chk(tag, tx_log.pop_front(), exp_bytes.pop_front());
    chk({tag, "_leftover"}, exp_bytes.size() + tx_log.size(), 0);
  endtask
  task automatic check_words(input string tag);
    chk({tag, "_count"}, words.size(), exp_words.size());
    while (exp_words.size() > 0 && words.size() > 0) chk(tag, words.pop_front(), exp_words.pop_front());
    words.delete();
    exp_words.delete();
  endtask
  task automatic load_prog;
    rom[0] = 32'h2001_0005;
    rom[1] = 32'h2002_0003;
    rom[2] = 32'hFC00_0000;
    for (int i = 3; i < 16; i++) rom[i] = 32'h0000_0000;
  endtask
  initial begin
    int halt_cyc;
    load_prog();
    repeat (3) @(negedge clk);
    chk("rst_state", state_dbg, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_addr", prog_address, 32'd0);
    rst = 0;
    send_rx(8'hAA);
    repeat (2) @(negedge clk);
    chk("rx_idle_discard", words.size(), 0);
    exp_bytes.push_back(8'h69);
    for (int i = 0; i < 3; i++) push_word_bytes(rom[i]);
    exp_bytes.push_back(8'h63);
    pulse_start(1'b1);
    for (int k = 0; k < 500 && tx_log.size() < 3; k++) @(negedge clk);
    pulse_start(1'b0);
    wait_tx(14);
    halt_cyc = tx_cyc[12];
    chk("gap_ok", (tx_cyc[13] - halt_cyc) > GAP, 1'b1);
    chk("prog_addr_end", prog_address, 32'd8);
    check_bytes("dl_cont");
    for (int k = 0; k < 50 && state_dbg !== 4'd8; k++) @(negedge clk);
    chk("in_receive", state_dbg, 4'd8);
    for (int n = 0; n < 50; n++) begin
      push_dump_word(n);
      for (int b = 0; b < 4; b++) send_rx(8'(n));
    end
    for (int k = 0; k < 20 && busy; k++) @(negedge clk);
    check_words("dump");
    chk("done_pulses", done_cnt, 1);
    chk("dump_error", error, 1'b0);
    chk("dump_idle", state_dbg, 4'd0);
    exp_bytes.push_back(8'h69);
    for (int i = 0; i < 3; i++) push_word_bytes(rom[i]);
    exp_bytes.push_back(8'h73);
    pulse_start(1'b0);
    wait_tx(14);
    check_bytes("dl_step");
    for (int k = 0; k < 50 && state_dbg !== 4'd8; k++) @(negedge clk);
    push_dump_word(0);
    push_dump_word(1);
    for (int i = 0; i < 10; i++) send_rx(8'(i / 4));
    wait_idle(TMO + 100);
    chk("tmo_error", error, 1'b1);
    chk("tmo_no_done", done_cnt, 1);
    check_words("tmo");
    for (int i = 0; i < 16; i++) rom[i] = 32'h1000_0000 + 32'(i * 32'h0101);
    exp_bytes.push_back(8'h69);
    for (int i = 0; i < 4; i++) push_word_bytes(rom[i]);
    pulse_start(1'b1);
    for (int k = 0; k < 10 && error; k++) @(negedge clk);
    chk("start_clears_error", error, 1'b0);
    wait_tx(17);
    wait_idle(200);
    repeat (40) @(negedge clk);
    chk("max_error", error, 1'b1);
    check_bytes("max_words");
    load_prog();
    pulse_start(1'b1);
    for (int k = 0; k < 50 && tx_ready !== 1'b1; k++) @(negedge clk);
    chk("pre_rst_tx_ready", tx_ready, 1'b1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_tx_ready", tx_ready, 1'b0);
    chk("rst_mid_state", state_dbg, 4'd0);
    chk("rst_mid_busy", busy, 1'b0);
    rst = 0;
    repeat (6) @(negedge clk);
    tx_log.delete();
    tx_cyc.delete();
    pulse_start(1'b1);
    wait_tx(1);
    chk("restart_byte", tx_log[0], 8'h69);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
